rendering_frame_ctrl: RTL and testbench

RENDERING_FRAME_CTRL -- requirements
Module: rendering_frame_ctrl

---
 rtl/rendering_ctrl_pkg.sv | 14 +
 rtl/rendering_xfer_gate.sv | 44 ++++
 rtl/rendering_frame_ctrl.sv | 146 ++++++++++++++
 tb/tb_rendering_frame_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rendering_ctrl_pkg.sv
// rtl/rendering_ctrl_pkg.sv - shared types and widths for the rendering frame controller
package rendering_ctrl_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/rendering_xfer_gate.sv
// rtl/rendering_xfer_gate.sv - gated vld/ack pass-through with per-frame word count
module rendering_xfer_gate
  import rendering_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [CNT_W-1:0]  limit,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_vld,
  output logic              src_ack,
  output logic [DATA_W-1:0] dst_data,
  output logic              dst_vld,
  input  logic              dst_ack,
  output logic [CNT_W-1:0]  count,
  output logic              fire,
  output logic              reached_next
);

  logic             gate;
  logic [CNT_W-1:0] count_next;

  // The channel is open only while running and short of the frame quota,
  // so the count can never pass the limit and never wraps.
  assign gate         = enable && (count < limit);
  assign dst_data     = src_data;
  assign dst_vld      = src_vld && gate;
  assign src_ack      = dst_ack && gate;
  assign fire         = src_vld && dst_ack && gate;
  assign count_next   = count + CNT_W'(fire);
  // Includes this cycle's transfer so the FSM can leave RUN right after the last word.
  assign reached_next = (count_next == limit);

  // Word counter: cleared on reset or frame accept, bumped on each transfer.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/rendering_frame_ctrl.sv
// rtl/rendering_frame_ctrl.sv - frame sequencer between host and rendering pipeline
module rendering_frame_ctrl
  import rendering_ctrl_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              ap_idle,
  input  logic [CNT_W-1:0]  cfg_in_words,
  input  logic [CNT_W-1:0]  cfg_out_words,
  input  logic [CNT_W-1:0]  cfg_timeout,
  input  logic [DATA_W-1:0] Host_in_V_V,
  input  logic              Host_in_V_V_ap_vld,
  output logic              Host_in_V_V_ap_ack,
  output logic [DATA_W-1:0] Pipe_out_V_V,
  output logic              Pipe_out_V_V_ap_vld,
  input  logic              Pipe_out_V_V_ap_ack,
  input  logic [DATA_W-1:0] Pipe_in_V_V,
  input  logic              Pipe_in_V_V_ap_vld,
  output logic              Pipe_in_V_V_ap_ack,
  output logic [DATA_W-1:0] Host_out_V_V,
  output logic              Host_out_V_V_ap_vld,
  input  logic              Host_out_V_V_ap_ack,
  output logic [CNT_W-1:0]  in_count,
  output logic [CNT_W-1:0]  out_count,
  output logic              err_timeout
);

  state_t           state;
  logic [CNT_W-1:0] cfg_in_q;
  logic [CNT_W-1:0] cfg_out_q;
  logic [CNT_W-1:0] cfg_to_q;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_inc;
  logic             accept;
  logic             run;
  logic             in_fire;
  logic             out_fire;
  logic             in_reached;
  logic             out_reached;
  logic             stall_hit;
  logic             idle_q;
  logic             done_q;
  logic             err_q;

  assign accept      = (state == ST_IDLE) && ap_start;
  assign run         = (state == ST_RUN);
  assign ap_ready    = accept;
  assign ap_idle     = idle_q;
  assign ap_done     = done_q;
  assign err_timeout = err_q;

  // A stall cycle is a RUN cycle with no transfer on either channel; the
  // limit is hit when this cycle would bring the stall count up to it.
  assign stall_inc = stall_cnt + CNT_W'(1);
  assign stall_hit = (cfg_to_q != '0) && !(in_fire || out_fire) && (stall_inc == cfg_to_q);

  rendering_xfer_gate u_in_gate (
    .clk          (ap_clk),
    .rst          (ap_rst),
    .clear        (accept),
    .enable       (run),
    .limit        (cfg_in_q),
    .src_data     (Host_in_V_V),
    .src_vld      (Host_in_V_V_ap_vld),
    .src_ack      (Host_in_V_V_ap_ack),
    .dst_data     (Pipe_out_V_V),
    .dst_vld      (Pipe_out_V_V_ap_vld),
    .dst_ack      (Pipe_out_V_V_ap_ack),
    .count        (in_count),
    .fire         (in_fire),
    .reached_next (in_reached)
  );

  rendering_xfer_gate u_out_gate (
    .clk          (ap_clk),
    .rst          (ap_rst),
    .clear        (accept),
    .enable       (run),
    .limit        (cfg_out_q),
    .src_data     (Pipe_in_V_V),
    .src_vld      (Pipe_in_V_V_ap_vld),
    .src_ack      (Pipe_in_V_V_ap_ack),
    .dst_data     (Host_out_V_V),
    .dst_vld      (Host_out_V_V_ap_vld),
    .dst_ack      (Host_out_V_V_ap_ack),
    .count        (out_count),
    .fire         (out_fire),
    .reached_next (out_reached)
  );

  // Frame FSM: latches config at accept, watches completion and stalls, registers status outputs.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state     <= ST_IDLE;
      idle_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cfg_in_q  <= '0;
      cfg_out_q <= '0;
      cfg_to_q  <= '0;
      stall_cnt <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ap_start) begin
            cfg_in_q  <= cfg_in_words;
            cfg_out_q <= cfg_out_words;
            cfg_to_q  <= cfg_timeout;
            stall_cnt <= '0;
            err_q     <= 1'b0;
            idle_q    <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if ((cfg_to_q == '0) || in_fire || out_fire) begin
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_inc;
          end
          if (in_reached && out_reached) begin
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else if (stall_hit) begin
            done_q <= 1'b1;
            err_q  <= 1'b1;
            state  <= ST_ERR;
          end
        end
        ST_DONE, ST_ERR: begin
          idle_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: begin
          idle_q <= 1'b1;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rendering_frame_ctrl.sv
// tb/tb_rendering_frame_ctrl.sv - self-checking bench for rendering_frame_ctrl
module tb_rendering_frame_ctrl;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_ready, ap_done, ap_idle;
  logic [15:0] cfg_in_words = '0, cfg_out_words = '0, cfg_timeout = '0;
  logic [31:0] Host_in_V_V = '0;
  logic        Host_in_V_V_ap_vld = 1'b0, Host_in_V_V_ap_ack;
  logic [31:0] Pipe_out_V_V;
  logic        Pipe_out_V_V_ap_vld, Pipe_out_V_V_ap_ack = 1'b0;
  logic [31:0] Pipe_in_V_V = '0;
  logic        Pipe_in_V_V_ap_vld = 1'b0, Pipe_in_V_V_ap_ack;
  logic [31:0] Host_out_V_V;
  logic        Host_out_V_V_ap_vld, Host_out_V_V_ap_ack = 1'b0;
  logic [15:0] in_count, out_count;
  logic        err_timeout;

  always #5 ap_clk = ~ap_clk;

  rendering_frame_ctrl dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_idle(ap_idle),
    .cfg_in_words(cfg_in_words), .cfg_out_words(cfg_out_words), .cfg_timeout(cfg_timeout),
    .Host_in_V_V(Host_in_V_V), .Host_in_V_V_ap_vld(Host_in_V_V_ap_vld),
    .Host_in_V_V_ap_ack(Host_in_V_V_ap_ack),
    .Pipe_out_V_V(Pipe_out_V_V), .Pipe_out_V_V_ap_vld(Pipe_out_V_V_ap_vld),
    .Pipe_out_V_V_ap_ack(Pipe_out_V_V_ap_ack),
    .Pipe_in_V_V(Pipe_in_V_V), .Pipe_in_V_V_ap_vld(Pipe_in_V_V_ap_vld),
    .Pipe_in_V_V_ap_ack(Pipe_in_V_V_ap_ack),
    .Host_out_V_V(Host_out_V_V), .Host_out_V_V_ap_vld(Host_out_V_V_ap_vld),
    .Host_out_V_V_ap_ack(Host_out_V_V_ap_ack),
    .in_count(in_count), .out_count(out_count), .err_timeout(err_timeout)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chkb(input string name, input logic act, input logic exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus sources ----------------
  logic [31:0] hq[$];
  logic [31:0] pq[$];
  int  hidx = 0, pidx = 0;
  bit  hin_en = 0, pin_en = 0, po_toggle = 0, po_ph = 0;
  bit  hin_fire = 0, pin_fire = 0;

  task automatic drive();
    Host_in_V_V_ap_vld = hin_en && (hidx < hq.size());
    Host_in_V_V        = (hidx < hq.size()) ? hq[hidx] : 32'h0;
    Pipe_in_V_V_ap_vld = pin_en && (pidx < pq.size());
    Pipe_in_V_V        = (pidx < pq.size()) ? pq[pidx] : 32'h0;
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
    if (hin_fire) hidx++;
    if (pin_fire) pidx++;
    if (po_toggle) begin
      po_ph = !po_ph;
      Pipe_out_V_V_ap_ack = po_ph;
    end
    drive();
  endtask

  // ---------------- model + monitor ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ERR = 3;
  int m_ph = M_IDLE;
  int m_ic = 0, m_oc = 0, m_ci = 0, m_co = 0, m_to = 0, m_st = 0;
  bit m_err = 0;
  bit gi, go, fi, fo;

  int cyc = 0;
  bit done_seen = 0, vld_seen = 0;
  int done_cyc = 0, ready_cyc = 0, ready_cnt = 0, last_hin_cyc = 0, last_any_cyc = 0, both_cnt = 0;
  int done_ic = 0, done_oc = 0;
  bit done_err = 0;
  logic [31:0] po_words[$];
  logic [31:0] ho_words[$];

  always @(negedge ap_clk) begin
    cyc++;
    gi = (m_ph == M_RUN) && (m_ic < m_ci);
    go = (m_ph == M_RUN) && (m_oc < m_co);
    fi = gi && Host_in_V_V_ap_vld && Pipe_out_V_V_ap_ack;
    fo = go && Pipe_in_V_V_ap_vld && Host_out_V_V_ap_ack;

    chkb("ap_idle", ap_idle, m_ph == M_IDLE);
    chkb("ap_ready", ap_ready, (m_ph == M_IDLE) && ap_start);
    chkb("ap_done", ap_done, (m_ph == M_DONE) || (m_ph == M_ERR));
    chkb("pipe_out_vld", Pipe_out_V_V_ap_vld, Host_in_V_V_ap_vld && gi);
    chkb("host_in_ack", Host_in_V_V_ap_ack, Pipe_out_V_V_ap_ack && gi);
    chkb("host_out_vld", Host_out_V_V_ap_vld, Pipe_in_V_V_ap_vld && go);
    chkb("pipe_in_ack", Pipe_in_V_V_ap_ack, Host_out_V_V_ap_ack && go);
    chkw("in_count", 32'(in_count), m_ic);
    chkw("out_count", 32'(out_count), m_oc);
    chkb("err_timeout", err_timeout, m_err);
    if (Host_in_V_V_ap_vld && gi) chkw("pipe_out_data", Pipe_out_V_V, Host_in_V_V);
    if (Pipe_in_V_V_ap_vld && go) chkw("host_out_data", Host_out_V_V, Pipe_in_V_V);

    hin_fire = Host_in_V_V_ap_vld && Host_in_V_V_ap_ack;
    pin_fire = Pipe_in_V_V_ap_vld && Pipe_in_V_V_ap_ack;
    if (Pipe_out_V_V_ap_vld && Pipe_out_V_V_ap_ack) begin
      po_words.push_back(Pipe_out_V_V);
      last_hin_cyc = cyc;
      last_any_cyc = cyc;
    end
    if (Host_out_V_V_ap_vld && Host_out_V_V_ap_ack) begin
      ho_words.push_back(Host_out_V_V);
      last_any_cyc = cyc;
    end
    if (Pipe_out_V_V_ap_vld && Pipe_out_V_V_ap_ack && Host_out_V_V_ap_vld && Host_out_V_V_ap_ack)
      both_cnt++;
    if (Pipe_out_V_V_ap_vld || Host_out_V_V_ap_vld) vld_seen = 1;
    if (ap_ready) begin
      ready_cnt++;
      ready_cyc = cyc;
    end
    if (ap_done) begin
      done_seen = 1;
      done_cyc  = cyc;
      done_ic   = int'(in_count);
      done_oc   = int'(out_count);
      done_err  = err_timeout;
    end

    if (ap_rst) begin
      m_ph = M_IDLE; m_ic = 0; m_oc = 0; m_st = 0; m_err = 0;
    end else begin
      case (m_ph)
        M_IDLE: if (ap_start) begin
          m_ci = int'(cfg_in_words); m_co = int'(cfg_out_words); m_to = int'(cfg_timeout);
          m_ic = 0; m_oc = 0; m_st = 0; m_err = 0; m_ph = M_RUN;
        end
        M_RUN: begin
          m_ic += int'(fi);
          m_oc += int'(fo);
          if (m_ic == m_ci && m_oc == m_co) m_ph = M_DONE;
          else if (m_to != 0) begin
            if (fi || fo) m_st = 0;
            else begin
              m_st++;
              if (m_st == m_to) begin
                m_ph = M_ERR;
                m_err = 1;
              end
            end
          end
        end
        default: m_ph = M_IDLE;
      endcase
    end
  end

  // ---------------- test helpers ----------------
  task automatic start_frame(input int ci, input int co, input int to, input int hold);
    cfg_in_words = 16'(ci); cfg_out_words = 16'(co); cfg_timeout = 16'(to);
    done_seen = 0; vld_seen = 0; ready_cnt = 0; both_cnt = 0;
    po_words.delete(); ho_words.delete();
    hidx = 0; pidx = 0;
    drive();
    ap_start = 1'b1;
    for (int i = 0; i < hold; i++) tick();
    ap_start = 1'b0;
    cfg_in_words = 16'd1; cfg_out_words = 16'd9; cfg_timeout = 16'd1;
  endtask

  task automatic wait_done(input string name, input int max);
    int n = 0;
    while (!done_seen && n < max) begin
      tick();
      n++;
    end
    chkb({name, "_done_seen"}, done_seen, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected end before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    Host_out_V_V_ap_ack = 1'b1;
    tick(); tick();
    ap_rst = 1'b0;
    chkb("rst_idle", ap_idle, 1'b1);
    chkw("rst_in_count", 32'(in_count), 32'd0);
    chkb("rst_err", err_timeout, 1'b0);
    tick();

    // basic frame 4 in / 2 out, sinks always ready
    hq = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    pq = '{32'hA0A0A0A0, 32'hB1B1B1B1};
    hin_en = 1; pin_en = 1; Pipe_out_V_V_ap_ack = 1'b1;
    start_frame(4, 2, 0, 1);
    wait_done("t1", 40);
    chkw("t1_po_n", 32'(po_words.size()), 32'd4);
    for (int i = 0; i < 4 && i < po_words.size(); i++) chkw("t1_po_word", po_words[i], hq[i]);
    chkw("t1_ho_n", 32'(ho_words.size()), 32'd2);
    for (int i = 0; i < 2 && i < ho_words.size(); i++) chkw("t1_ho_word", ho_words[i], pq[i]);
    chkw("t1_done_ic", 32'(done_ic), 32'd4);
    chkw("t1_done_oc", 32'(done_oc), 32'd2);
    chkw("t1_done_lat", 32'(done_cyc - last_any_cyc), 32'd1);
    chkw("t1_frame_len", 32'(done_cyc - ready_cyc), 32'd5);
    tick(); tick();

    // quota of 3 with source still offering a 4th word; return withheld
    hq = '{32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004};
    pq.delete();
    pin_en = 0;
    start_frame(3, 1, 0, 2);
    for (int i = 0; i < 4; i++) tick();
    chkw("t2_in_count", 32'(in_count), 32'd3);
    chkb("t2_vld_held", Host_in_V_V_ap_vld, 1'b1);
    chkb("t2_ack_blocked", Host_in_V_V_ap_ack, 1'b0);
    chkw("t2_src_idx", 32'(hidx), 32'd3);
    pq = '{32'hD00DD00D};
    pin_en = 1;
    drive();
    wait_done("t2", 20);
    chkw("t2_po_n", 32'(po_words.size()), 32'd3);
    chkw("t2_ready_cnt", 32'(ready_cnt), 32'd1);
    tick(); tick();

    // empty frame
    hq = '{32'hEEEE0000};
    pq = '{32'hEEEE1111};
    start_frame(0, 0, 0, 1);
    wait_done("t3", 10);
    chkw("t3_frame_len", 32'(done_cyc - ready_cyc), 32'd2);
    chkb("t3_no_vld", vld_seen, 1'b0);
    tick(); tick();

    // stall timeout: pipeline never returns
    hq = '{32'h51515151, 32'h52525252};
    pq.delete();
    pin_en = 0;
    start_frame(2, 1, 5, 1);
    wait_done("t4", 30);
    chkb("t4_err", done_err, 1'b1);
    chkw("t4_done_oc", 32'(done_oc), 32'd0);
    chkw("t4_done_ic", 32'(done_ic), 32'd2);
    chkw("t4_err_lat", 32'(done_cyc - last_hin_cyc), 32'd6);
    chkw("t4_frame_len", 32'(done_cyc - ready_cyc), 32'd8);
    tick(); tick(); tick();
    chkb("t4_err_sticky", err_timeout, 1'b1);
    chkw("t4_ic_hold", 32'(in_count), 32'd2);

    // Pipe_out ack toggles, both directions active together
    hq = '{32'h61000001, 32'h61000002, 32'h61000003, 32'h61000004};
    pq = '{32'h72000001, 32'h72000002, 32'h72000003, 32'h72000004};
    pin_en = 1; po_toggle = 1; po_ph = 0; Pipe_out_V_V_ap_ack = 1'b0;
    start_frame(4, 4, 0, 1);
    chkb("t5_err_cleared", err_timeout, 1'b0);
    wait_done("t5", 40);
    chkw("t5_po_n", 32'(po_words.size()), 32'd4);
    for (int i = 0; i < 4 && i < po_words.size(); i++) chkw("t5_po_word", po_words[i], hq[i]);
    chkw("t5_ho_n", 32'(ho_words.size()), 32'd4);
    for (int i = 0; i < 4 && i < ho_words.size(); i++) chkw("t5_ho_word", ho_words[i], pq[i]);
    chkw("t5_both_cycles", 32'(both_cnt), 32'd2);
    chkw("t5_frame_len", 32'(done_cyc - ready_cyc), 32'd8);
    po_toggle = 0; Pipe_out_V_V_ap_ack = 1'b1;
    tick(); tick();

    // reset in the middle of a frame
    hq = '{32'h81, 32'h82, 32'h83, 32'h84};
    pq.delete();
    pin_en = 0;
    start_frame(4, 4, 0, 1);
    begin
      int n = 0;
      while (in_count != 16'd2 && n < 10) begin
        tick();
        n++;
      end
    end
    chkw("t6_mid_count", 32'(in_count), 32'd2);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    chkb("t6_idle", ap_idle, 1'b1);
    chkw("t6_in_count", 32'(in_count), 32'd0);
    chkb("t6_po_vld", Pipe_out_V_V_ap_vld, 1'b0);
    chkb("t6_hin_ack", Host_in_V_V_ap_ack, 1'b0);
    tick(); tick(); tick();
    chkb("t6_no_done", done_seen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
